// File: rtl/reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// reg_share_arbiter
//
// Four requesters share a single N-bit register. A round-robin arbiter picks
// one requester in IDLE. The winner holds GNT for a GRANT cycle, in which its
// data slice is written. It then holds GNT for an ACK cycle, in which it
// receives a one-cycle ACK pulse.
//
// Ports
//   CLK    in   1    clock, rising edge
//   CLR    in   1    synchronous active-high reset, overrides every other input
//   REQ    in   4    write request per requester
//   D      in   4*N  packed write data, requester i at [i*N +: N]
//   LOCK   in   4    hold-ownership request (only with REG_SHARE_LOCK_EN)
//   GNT    out  4    one-hot grant, zero in IDLE
//   ACK    out  4    one-cycle write-complete pulse to the granted requester
//   Q      out  N    shared register contents
//   OWNER  out  2    index of the last requester acknowledged
//   BUSY   out  1    high whenever the FSM is not in IDLE
//
// Configuration macro
//   REG_SHARE_LOCK_EN  When this macro is defined, an ACK cycle with LOCK[sel]
//                      set returns straight to GRANT for the same requester.
//                      When it is undefined, LOCK is ignored.
// -----------------------------------------------------------------------------
module reg_share_arbiter #(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic [3:0]     REQ,
    input  logic [4*N-1:0] D,
    input  logic [3:0]     LOCK,
    output logic [3:0]     GNT,
    output logic [3:0]     ACK,
    output logic [N-1:0]   Q,
    output logic [1:0]     OWNER,
    output logic           BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   sel_q,   sel_d;
    logic [1:0]   ptr_q,   ptr_d;
    logic [1:0]   owner_q, owner_d;
    logic [N-1:0] q_q,     q_d;
    logic [3:0]   gnt_q,   gnt_d;
    logic [3:0]   ack_q,   ack_d;
    logic         busy_q,  busy_d;

    // Round-robin pick. The search starts at ptr+1 and wraps. The ptr slot is
    // visited last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

`ifndef REG_SHARE_LOCK_EN
    // LOCK has no effect in this build. It is folded into a sink net so it
    // stays connected.
    logic unused_lock_s;
    assign unused_lock_s = ^LOCK;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        q_d     = q_q;
        case (state_q)
            S_IDLE: begin
                if (REQ != 4'b0000) begin
                    sel_d   = rr_pick(REQ, ptr_q);
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // A withdrawn request abandons the write. Q and ptr are left
                // untouched.
                if (REQ[sel_q]) begin
                    q_d     = D[int'(sel_q)*N +: N];
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                ptr_d   = sel_q;
                owner_d = sel_q;
`ifdef REG_SHARE_LOCK_EN
                // A locked owner skips arbitration and keeps sel.
                if (LOCK[sel_q]) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The outputs are computed from next state so that the registered
        // copies line up with the state they describe.
        if (state_d != S_IDLE) begin
            gnt_d = onehot(sel_d);
        end else begin
            gnt_d = 4'b0000;
        end
        if (state_d == S_ACK) begin
            ack_d = onehot(sel_d);
        end else begin
            ack_d = 4'b0000;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers. Requester 0 gets first priority after CLR.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            owner_q <= 2'd0;
            q_q     <= '0;
            gnt_q   <= 4'b0000;
            ack_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign ACK   = ack_q;
    assign Q     = q_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;

endmodule
